// File: rtl/lsu_stage_if.sv
// Data-memory request/response bus between the load/store stage (master)
// and the memory (slave).
interface lsu_stage_if #(
  parameter int WIDTH = 32
);
  logic               mem_req;
  logic               mem_we;
  logic [WIDTH-1:0]   mem_addr;
  logic [WIDTH-1:0]   mem_wdata;
  logic [WIDTH/8-1:0] mem_wmask;
  logic               mem_ready;
  logic               mem_rvalid;
  logic [WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage: captures one EXU bundle, performs at most one memory
// access, aligns/extends load data and emits the write-back bundle.
module lsu_stage #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          exu_valid,
  input  logic [108:0]  exu_data,
  output logic          lsu_ready,
  lsu_stage_if.master   mem,
  output logic          lsu_valid,
  output logic [103:0]  lsu_data,
  output logic          lsu_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e             state_q, state_d;
  logic [108:0]       cap_q, cap_d;
  logic [WIDTH-1:0]   ld_q, ld_d;
  logic               err_q, err_d;
  logic               accept;
  logic               acc_err;
  logic               acc_mem;
  logic               cap_load;
  logic [1:0]         cap_off;

  // Both enables set means store; loads and stores have different legal funct3 sets.
  function automatic logic mem_err(input logic ren, input logic wen,
                                   input logic [2:0] f3, input logic [1:0] off);
    logic illegal;
    logic misal;
    illegal = 1'b0;
    if (wen)
      illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    else if (ren)
      illegal = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    misal = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    return (ren | wen) & (illegal | misal);
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] rdata,
                                           input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = rdata >> {off, 3'b000};
    res = '0;
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b010:  res = sh;
      3'b100:  res = {24'b0, sh[7:0]};
      3'b101:  res = {16'b0, sh[15:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  assign accept   = exu_valid && (state_q == IDLE);
  assign acc_mem  = exu_data[44] | exu_data[43];
  assign acc_err  = mem_err(exu_data[44], exu_data[43], exu_data[42:40], exu_data[78:77]);
  assign cap_load = cap_q[44] & ~cap_q[43];
  assign cap_off  = cap_q[78:77];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cap_q   <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    ld_d    = ld_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cap_d   = exu_data;
          ld_d    = '0;
          err_d   = acc_err;
          state_d = (acc_mem && !acc_err) ? REQ : DONE;
        end
      end
      REQ: begin
        if (mem.mem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          state_d = DONE;
          if (cap_load) ld_d = load_ext(mem.mem_rdata, cap_off, cap_q[42:40]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields come straight from the captured bundle, so they stay stable across REQ.
  always_comb begin
    lsu_ready     = (state_q == IDLE);
    mem.mem_req   = (state_q == REQ);
    mem.mem_we    = cap_q[43];
    mem.mem_addr  = {cap_q[108:79], 2'b00};
    mem.mem_wdata = cap_q[76:45] << {cap_off, 3'b000};
    mem.mem_wmask = cap_q[43] ? store_mask(cap_q[41:40], cap_off) : 4'b0000;
    lsu_valid     = (state_q == DONE);
    lsu_err       = (state_q == DONE) && err_q;
    lsu_data      = {cap_q[108:77], ld_q, cap_q[39] & ~err_q, cap_q[38:0]};
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Randomized and directed bench for lsu_stage with a behavioural memory and
// an arithmetic reference model of the load/store rules.
module tb_lsu_stage;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         exu_valid = 1'b0;
  logic [108:0] exu_data = '0;
  logic         lsu_ready, lsu_valid, lsu_err;
  logic [103:0] lsu_data;
  logic [103:0] got;
  int           n_checks = 0;
  int           n_errors = 0;

  lsu_stage_if #(.WIDTH(32)) mem ();

  lsu_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .exu_valid (exu_valid),
    .exu_data  (exu_data),
    .lsu_ready (lsu_ready),
    .mem       (mem),
    .lsu_valid (lsu_valid),
    .lsu_data  (lsu_data),
    .lsu_err   (lsu_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [108:0] pack(input logic [31:0] alu, input logic [31:0] sd,
                                        input logic ren, input logic wen, input logic [2:0] f3,
                                        input logic rdw, input logic [4:0] rda,
                                        input logic [1:0] sel, input logic [31:0] csr);
    return {alu, sd, ren, wen, f3, rdw, rda, sel, csr};
  endfunction

  // Reference: sizes, legality and extension computed with plain integer arithmetic.
  function automatic void model(input logic [108:0] d, input logic [31:0] rdata,
                                output logic [103:0] xdata, output logic xerr,
                                output logic xmem, output logic xstore,
                                output logic [36:0] xctl, output logic [31:0] xwdata);
    logic [31:0] alu, sd, ld, addr;
    logic [2:0]  f3;
    logic        load, legal, aligned;
    logic [3:0]  mask;
    int          off, size;
    longint      v;
    alu    = d[108:77];
    sd     = d[76:45];
    f3     = d[42:40];
    xstore = d[43];
    load   = d[44] && !d[43];
    off    = int'(alu % 4);
    size   = 1 << f3[1:0];
    legal  = xstore ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    aligned = (off % size) == 0;
    xerr   = (load || xstore) && !(legal && aligned);
    xmem   = (load || xstore) && !xerr;
    ld     = '0;
    if (load && !xerr) begin
      v = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      ld = v[31:0];
    end
    addr   = alu - 32'(off);
    mask   = xstore ? 4'((((1 << size) - 1) << off)) : 4'b0000;
    xwdata = sd << (8 * off);
    xctl   = {xstore, addr, mask};
    xdata  = {alu, ld, d[39] && !xerr, d[38:0]};
  endfunction

  task automatic run_txn(input logic [108:0] d, input logic [31:0] rdata,
                         input int rdy_dly, input int rv_dly, output logic [103:0] obs);
    logic [103:0] xdata;
    logic [36:0]  xctl;
    logic [31:0]  xwdata;
    logic         xerr, xmem, xstore, in_wait;
    int           n, nreq, nwait;
    model(d, rdata, xdata, xerr, xmem, xstore, xctl, xwdata);
    chk("ready_before", 128'(lsu_ready), 128'(1));
    exu_valid = 1'b1;
    exu_data  = d;
    @(posedge clk); #1;
    exu_valid = 1'b0;
    exu_data  = 109'({$urandom(), $urandom(), $urandom(), $urandom()});
    n = 1; nreq = 0; nwait = 0; in_wait = 1'b0;
    while (!lsu_valid && n < 300) begin
      mem.mem_ready  = 1'b0;
      mem.mem_rvalid = 1'b0;
      mem.mem_rdata  = $urandom();
      exu_valid      = 1'b0;
      if (in_wait) begin
        chk("req_low_in_wait", 128'(mem.mem_req), 128'(0));
        mem.mem_ready = 1'($urandom_range(0, 1));
        if (nwait == rv_dly) begin
          mem.mem_rvalid = 1'b1;
          mem.mem_rdata  = rdata;
        end
        nwait++;
      end else if (mem.mem_req) begin
        chk("bus_ctrl", 128'({mem.mem_we, mem.mem_addr, mem.mem_wmask}), 128'(xctl));
        if (xstore) chk("bus_wdata", 128'(mem.mem_wdata), 128'(xwdata));
        mem.mem_rvalid = 1'($urandom_range(0, 1));
        exu_valid      = 1'($urandom_range(0, 1));
        if (nreq == rdy_dly) begin
          mem.mem_ready = 1'b1;
          in_wait = 1'b1;
        end
        nreq++;
      end
      @(posedge clk); #1;
      n++;
    end
    mem.mem_ready  = 1'b0;
    mem.mem_rvalid = 1'b0;
    exu_valid      = 1'b0;
    if (n >= 300) chk("timeout", 128'(n), 128'(0));
    chk("latency", 128'(n), 128'(xmem ? (3 + rdy_dly + rv_dly) : 1));
    chk("req_cycles", 128'(nreq), 128'(xmem ? (rdy_dly + 1) : 0));
    chk("lsu_valid", 128'(lsu_valid), 128'(1));
    chk("lsu_data", 128'(lsu_data), 128'(xdata));
    chk("lsu_err", 128'(lsu_err), 128'(xerr));
    obs = lsu_data;
    @(posedge clk); #1;
    chk("valid_pulse", 128'(lsu_valid), 128'(0));
    chk("ready_after", 128'(lsu_ready), 128'(1));
    chk("data_hold", 128'(lsu_data), 128'(xdata));
  endtask

  initial begin
    logic [108:0] d;
    logic [2:0]   f3;
    logic         ren, wen;
    mem.mem_ready  = 1'b0;
    mem.mem_rvalid = 1'b0;
    mem.mem_rdata  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 128'(lsu_ready), 128'(1));
    chk("rst_req", 128'(mem.mem_req), 128'(0));
    chk("rst_valid", 128'(lsu_valid), 128'(0));
    chk("rst_err", 128'(lsu_err), 128'(0));
    chk("rst_data", 128'(lsu_data), 128'(0));
    chk("rst_bus", 128'({mem.mem_we, mem.mem_addr, mem.mem_wdata, mem.mem_wmask}), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU pass-through
    run_txn(pack(32'h1234, 32'h5555, 1'b0, 1'b0, 3'd0, 1'b1, 5'd5, 2'd1, 32'hC0DE), 32'h0, 0, 0, got);
    chk("alu_result", 128'(got[103:72]), 128'(32'h1234));
    chk("alu_ld_zero", 128'(got[71:40]), 128'(0));
    chk("alu_rd", 128'(got[38:34]), 128'(5));

    // Loads
    run_txn(pack(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b000, 1'b1, 5'd7, 2'd2, 32'h0), 32'h80FF7F01, 2, 3, got);
    chk("lb_sext", 128'(got[71:40]), 128'(32'hFFFFFF80));
    chk("lb_addr", 128'(mem.mem_addr), 128'(32'h80000000));
    chk("lb_mask", 128'(mem.mem_wmask), 128'(0));
    run_txn(pack(32'h00001002, 32'h0, 1'b1, 1'b0, 3'b101, 1'b1, 5'd8, 2'd2, 32'h0), 32'hBEEF1234, 1, 0, got);
    chk("lhu", 128'(got[71:40]), 128'(32'h0000BEEF));
    run_txn(pack(32'h00001000, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd9, 2'd2, 32'h0), 32'hBEEF1234, 0, 1, got);
    chk("lw", 128'(got[71:40]), 128'(32'hBEEF1234));

    // Stores
    run_txn(pack(32'h00002001, 32'h000000AB, 1'b0, 1'b1, 3'b000, 1'b0, 5'd0, 2'd0, 32'h0), 32'h0, 1, 2, got);
    chk("sb_we", 128'(mem.mem_we), 128'(1));
    chk("sb_mask", 128'(mem.mem_wmask), 128'(4'b0010));
    chk("sb_lane", 128'(mem.mem_wdata[15:8]), 128'(8'hAB));
    run_txn(pack(32'h00002002, 32'h0000CAFE, 1'b0, 1'b1, 3'b001, 1'b0, 5'd0, 2'd0, 32'h0), 32'h0, 0, 0, got);
    chk("sh_mask", 128'(mem.mem_wmask), 128'(4'b1100));

    // Errors
    run_txn(pack(32'h00003002, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd3, 2'd2, 32'h0), 32'h0, 0, 0, got);
    chk("lw_mis_rdwen", 128'(got[39]), 128'(0));
    run_txn(pack(32'h00003000, 32'h0, 1'b1, 1'b0, 3'b011, 1'b1, 5'd3, 2'd2, 32'h0), 32'h0, 0, 0, got);
    chk("ld_f3_rdwen", 128'(got[39]), 128'(0));

    // Reset while waiting for the response
    exu_valid = 1'b1;
    exu_data  = pack(32'h00004000, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd4, 2'd2, 32'h0);
    @(posedge clk); #1;
    exu_valid = 1'b0;
    mem.mem_ready = 1'b1;
    @(posedge clk); #1;
    mem.mem_ready = 1'b0;
    chk("rw_in_wait", 128'({lsu_ready, mem.mem_req}), 128'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rw_req_low", 128'(mem.mem_req), 128'(0));
    chk("rw_ready", 128'(lsu_ready), 128'(1));
    chk("rw_no_valid", 128'(lsu_valid), 128'(0));
    mem.mem_rvalid = 1'b1;
    mem.mem_rdata  = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem.mem_rvalid = 1'b0;
    chk("rw_late_rvalid", 128'(lsu_valid), 128'(0));
    chk("rw_idle", 128'(lsu_ready), 128'(1));
    run_txn(pack(32'h00004004, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd6, 2'd2, 32'h0), 32'h13579BDF, 1, 1, got);

    // Randomized mix of ALU ops, loads, stores and both-enable ops
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       begin ren = 1'b0; wen = 1'b0; end
        1:       begin ren = 1'b1; wen = 1'b0; end
        2:       begin ren = 1'b0; wen = 1'b1; end
        default: begin ren = 1'b1; wen = 1'b1; end
      endcase
      f3 = 3'($urandom_range(0, 7));
      d  = pack($urandom(), $urandom(), ren, wen, f3, 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom());
      run_txn(d, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Multi-cycle load/store stage of the NPC core. Sits between EXU (upstream) and the write-back stage (downstream).
- Accepts one packed instruction bundle from EXU and performs at most one data-memory access over a request/response bus.
- Aligns and extends load data, then emits the 104-bit bundle the write-back stage consumes, with a one-cycle valid pulse.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
- WIDTH, 32, datapath/address width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- exu_valid  in  1  EXU bundle valid, one-cycle pulse
- exu_data  in  109  packed fields, listed below:
  - [108:77] alu_result (also the memory address)
  - [76:45] store_data
  - [44] mem_ren
  - [43] mem_wen
  - [42:40] funct3
  - [39] rd_wen
  - [38:34] rd_addr
  - [33:32] rd_input_sel
  - [31:0] csr_data
- lsu_ready  out  1  high in IDLE: stage can accept exu_valid
- mem_req  out  1  memory request valid
- mem_we  out  1  1=write, 0=read
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  byte-lane-shifted store data
- mem_wmask  out  4  byte write mask; 0 for reads
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response: read data valid, or write complete
- mem_rdata  in  32  read word
- lsu_valid  out  1  one-cycle pulse: lsu_data valid
- lsu_data  out  104  packed output fields, listed below:
  - [103:72] alu_result
  - [71:40] load data
  - [39] rd_wen
  - [38:34] rd_addr
  - [33:32] rd_input_sel
  - [31:0] csr_data
- lsu_err  out  1  one-cycle pulse with lsu_valid: misaligned access or illegal funct3

Behaviour:
- Reset values: all outputs 0, except lsu_ready=1. State=IDLE. Capture register cleared.
- Bundle capture:
  - exu_data is captured on exu_valid & lsu_ready.
  - exu_valid while not ready is a protocol violation and is ignored.
- FSM states IDLE, REQ, WAIT, DONE; lsu_ready=1 only in IDLE:
  - IDLE → DONE: on accept with no memory op, or with an erroring memory op.
  - IDLE → REQ: on accept with mem_ren|mem_wen and no error.
  - REQ → WAIT: mem_req held high with stable addr/wdata/mask/we; advance the cycle mem_ready=1.
  - WAIT → DONE: mem_req=0; advance the cycle mem_rvalid=1, latching mem_rdata on reads.
  - DONE → IDLE: lsu_valid=1 for exactly one cycle.
- mem_rvalid handling:
  - Sampled only in WAIT; ignored in every other state.
  - mem_ready is ignored outside REQ.
- Latency from the accept edge to the lsu_valid cycle:
  - Non-memory instruction: 1 cycle.
  - Memory instruction: 1 + (cycles in REQ) + (cycles in WAIT).
- If both mem_ren and mem_wen are set, the op is treated as a store.
- Offset: off = alu_result[1:0].
- Load extraction, applied to mem_rdata >> (8*off):
  - funct3 000 LB: sign-extend bits [7:0].
  - funct3 001 LH: sign-extend bits [15:0].
  - funct3 010 LW: full word.
  - funct3 100 LBU / 101 LHU: zero-extend.
- Store lanes:
  - mem_wdata = store_data << (8*off).
  - mem_wmask: SB = 4'b0001<<off, SH = 4'b0011<<off, SW = 4'b1111.
- Error rules:
  - Misaligned: halfword with off[0]=1, or word with off≠0.
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - On error: no memory request, lsu_err=1 with lsu_valid, output rd_wen forced 0, load data=0.
- lsu_data rules:
  - Load-data field = extracted value for loads, 0 otherwise.
  - All other fields copy the captured bundle.
  - Fields hold until the next bundle; only lsu_valid pulses.
- Reset mid-operation:
  - Abandons the transaction; mem_req is low the cycle after rst.
  - A late mem_rvalid arrives in IDLE and is ignored.
  - No lsu_valid is produced for the abandoned bundle.

Test Plan:
- ALU op: exu_valid with mem_ren=mem_wen=0, alu_result=0x1234, rd_addr=5 → lsu_valid one cycle later. lsu_data[103:72]=0x1234, [71:40]=0, [38:34]=5. lsu_ready low exactly one cycle.
- LB with sign extension: addr 0x80000003, mem_rdata=0x80FF7F01, mem_ready after 2 cycles, mem_rvalid 3 cycles later:
  - mem_addr=0x80000000 and wmask=0.
  - Load data=0xFFFFFF80.
  - lsu_valid pulse on the cycle after rvalid.
- LHU / LW: addr offset 2, rdata=0xBEEF1234 → LHU gives 0x0000BEEF. Offset 0 LW → 0xBEEF1234.
- Stores:
  - SB addr 0x...01, store_data=0x000000AB → mem_we=1, wmask=4'b0010, wdata bits[15:8]=0xAB.
  - SH at offset 2 → wmask=4'b1100.
  - Completion only after mem_rvalid.
- Errors:
  - LW at offset 2 → no mem_req ever asserted; lsu_valid and lsu_err pulse 1 cycle after accept; rd_wen field=0.
  - Load with funct3=011 behaves the same way.
- Reset in WAIT: assert rst for 1 cycle while waiting → mem_req=0, lsu_ready=1. A subsequent mem_rvalid produces no lsu_valid, and the next bundle completes normally.
